// File: rtl/uart_frame_tx.sv
// uart_frame_tx: byte FIFO feeding a UART transmitter.
// A frame is a start bit, DATA_BITS payload bits sent LSB first, an optional
// parity bit, then STOP_BITS stop bits. Optional parity is enabled by the
// macro UART_TX_PARITY_EN, which also adds the PARITY_ODD parameter.
module uart_frame_tx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 860,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_END = TW'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    state_t               next_state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] frame_data;
    logic [TW-1:0]        bit_cnt;
    logic [IW-1:0]        bit_idx;
    logic [CW-1:0]        count_next;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 stop_end;
    logic                 last_bit;
    logic                 cnt_clr;
    logic                 idx_adv;
    logic                 tx_next;
    logic                 done_next;
    logic                 par_bit;

    // Full is judged from the registered count only, so a pop in the same
    // cycle never opens room for a write.
    assign wr_ready   = (fifo_count != FULL);
    assign push       = wr_valid & wr_ready;
    assign fifo_empty = (fifo_count == '0);
    assign count_next = fifo_count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    assign bit_end    = (bit_cnt == BIT_END);
    assign stop_end   = (bit_cnt == STOP_END);
    assign last_bit   = (bit_idx == LAST_IDX);

`ifdef UART_TX_PARITY_EN
    assign par_bit = (^frame_data) ^ (PARITY_ODD != 0);
`else
    assign par_bit = 1'b1;
`endif

    // Next-state, FIFO pop request and the line level for the current state.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        idx_adv    = 1'b0;
        tx_next    = 1'b1;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (bit_end) next_state = DATA;
            end
            DATA: begin
                tx_next = frame_data[bit_idx];
                if (bit_end) begin
                    if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                        next_state = PAR;
`else
                        next_state = STOP;
`endif
                    end else begin
                        idx_adv = 1'b1;
                    end
                end
            end
            PAR: begin
                tx_next = par_bit;
                if (bit_end) next_state = STOP;
            end
            STOP: begin
                tx_next = 1'b1;
                if (stop_end) begin
                    done_next = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bit timer restarts on every state change and at each payload bit boundary.
    assign cnt_clr = (next_state != state) || (state == IDLE) || ((state == DATA) && bit_end);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Bit-time counter and payload bit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            bit_idx <= '0;
        end else begin
            bit_cnt <= cnt_clr ? '0 : bit_cnt + 1'b1;
            if (state != DATA) bit_idx <= '0;
            else if (idx_adv)  bit_idx <= bit_idx + 1'b1;
        end
    end

    // Byte FIFO; the popped entry is latched as the frame being sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            frame_data <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data[DATA_BITS-1:0];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                frame_data <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
            end
            fifo_count <= count_next;
        end
    end

    // Registered outputs; they trail the state by one cycle, so busy and
    // frame_done line up with the final stop-bit cycle seen on tx.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx         <= tx_next;
            frame_done <= done_next;
            busy       <= (next_state != IDLE) || (count_next != '0);
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx (CLKS_PER_BIT=4). Writes push expected
// bytes; a monitor decodes every frame on tx and compares it cycle by cycle.
module tb_uart_frame_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FL = 44;
`else
    localparam int FL = 40;
`endif

    typedef struct {
        logic [7:0] data;
        bit         b2b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready, tx, busy, frame_done;
    logic [2:0] fifo_count;

    logic       valid_x = 1'b0;
    logic [7:0] data_b = '0;
    logic       ready_b, tx_b, busy_b, done_b;
    logic [2:0] count_b;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   frames_ok = 0;
    int   done_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (frame_done === 1'b1) done_total++;

    uart_frame_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .tx(tx), .busy(busy), .fifo_count(fifo_count), .frame_done(frame_done));

    uart_frame_tx #(.DATA_BITS(7), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .wr_valid(valid_x), .wr_data(data_b), .wr_ready(ready_b),
        .tx(tx_b), .busy(busy_b), .fifo_count(count_b), .frame_done(done_b));

`ifdef UART_TX_PARITY_EN
    logic       tx_p0, tx_p1, done_p0, done_p1, rdy_p0, rdy_p1, busy_p0, busy_p1;
    logic [2:0] cnt_p0, cnt_p1;
    logic [7:0] data_p = 8'h07;
    uart_frame_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_ODD(0)) dut_p0 (
        .clk(clk), .rst(rst), .wr_valid(valid_x), .wr_data(data_p), .wr_ready(rdy_p0),
        .tx(tx_p0), .busy(busy_p0), .fifo_count(cnt_p0), .frame_done(done_p0));
    uart_frame_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY_ODD(1)) dut_p1 (
        .clk(clk), .rst(rst), .wr_valid(valid_x), .wr_data(data_p), .wr_ready(rdy_p1),
        .tx(tx_p1), .busy(busy_p1), .fifo_count(cnt_p1), .frame_done(done_p1));
`endif

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Present one byte and hold it until accepted; returns accept cycle and stall count.
    task automatic wr(input logic [7:0] d, input bit b2b, output int acc, output int stalls);
        exp_t e;
        wr_valid = 1'b1;
        wr_data  = d;
        stalls   = 0;
        acc      = -1;
        while (stalls < 300) begin
            @(negedge clk);
            if (wr_ready === 1'b1) break;
            stalls++;
        end
        if (stalls >= 300) begin
            chk("write_accept_timeout", 32'(stalls), 32'd0);
            wr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc      = cyc;
        wr_valid = 1'b0;
        e.data   = d;
        e.b2b    = b2b;
        sbq.push_back(e);
    endtask

    task automatic until_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && busy === 1'b0) begin
                repeat (3) @(negedge clk);
                return;
            end
        end
        chk("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: waits for a start bit, then compares the whole frame against
    // the next scoreboard entry; a frame cut short by reset is dropped.
    initial begin : monitor
        exp_t       e;
        logic [7:0] d;
        logic       w;
        int         gap;
        int         bad;
        int         dcnt;
        int         dpos;
        bit         aborted;
        gap = 100;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 || tx !== 1'b0) begin
                gap++;
                continue;
            end
            if (sbq.size() == 0) begin
                chk("unexpected_frame", 32'd1, 32'd0);
                e.data = '0;
                e.b2b  = 1'b0;
            end else begin
                e = sbq.pop_front();
            end
            d = e.data;
            bad = 0; dcnt = 0; dpos = -1; aborted = 1'b0;
            for (int i = 0; i < FL; i++) begin
                if (i > 0) @(negedge clk);
                if (rst === 1'b1) begin
                    aborted = 1'b1;
                    break;
                end
                if (i < 4)       w = 1'b0;
                else if (i < 36) w = d[(i-4)/4];
`ifdef UART_TX_PARITY_EN
                else if (i < 40) w = ^d;
`endif
                else             w = 1'b1;
                if (tx !== w) bad++;
                if (frame_done === 1'b1) begin
                    dcnt++;
                    dpos = i;
                end
            end
            if (!aborted) begin
                frames_ok++;
                chk($sformatf("frame_bits_%02h", d), 32'(bad), 32'd0);
                chk($sformatf("frame_done_pos_%02h", d), 32'(dpos), 32'(FL - 1));
                chk($sformatf("frame_done_cnt_%02h", d), 32'(dcnt), 32'd1);
                if (e.b2b) chk($sformatf("b2b_gap_%02h", d), 32'(gap), 32'd0);
            end
            gap = 0;
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int acc, st, acc_a;
        logic [7:0] bytes2 [6];
        logic [7:0] bytes3 [5];
        logic       txs [48];
        logic       dns [48];
        logic       bsy [48];
        logic [2:0] cnts [48];
        logic       tb_s [48];
        logic       db_s [48];
        int         ndb;
        bytes2 = '{8'h01, 8'h82, 8'h43, 8'hC4, 8'h25, 8'hA6};
        bytes3 = '{8'h50, 8'h60, 8'h70, 8'h80, 8'h90};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single byte 0x55: latency, bit order and end-of-frame timing
        wr(8'h55, 1'b0, acc, st);
        for (int k = 0; k <= FL + 2; k++) begin
            @(negedge clk);
            txs[k] = tx; dns[k] = frame_done; bsy[k] = busy; cnts[k] = fifo_count;
        end
        chk("t1_count_k0", 32'(cnts[0]), 32'd1);
        chk("t1_busy_k0", 32'(bsy[0]), 32'd1);
        chk("t1_count_k1", 32'(cnts[1]), 32'd0);
        chk("t1_tx_k1", 32'(txs[1]), 32'd1);
        chk("t1_tx_k2", 32'(txs[2]), 32'd0);
        chk("t1_tx_k5", 32'(txs[5]), 32'd0);
        chk("t1_tx_k6", 32'(txs[6]), 32'd1);
        chk("t1_tx_k9", 32'(txs[9]), 32'd1);
        chk("t1_tx_k10", 32'(txs[10]), 32'd0);
        chk("t1_busy_last-1", 32'(bsy[FL]), 32'd1);
        chk("t1_done_last", 32'(dns[FL+1]), 32'd1);
        chk("t1_busy_last", 32'(bsy[FL+1]), 32'd0);
        chk("t1_tx_last", 32'(txs[FL+1]), 32'd1);
        chk("t1_done_after", 32'(dns[FL+2]), 32'd0);
        chk("t1_tx_after", 32'(txs[FL+2]), 32'd1);
        drain();
        @(posedge clk);
        #1;

        // Six writes into an idle transmitter: the sixth waits for a pop
        for (int i = 0; i < 6; i++) begin
            wr(bytes2[i], i != 0, acc, st);
            if (i == 4) chk("t2_stall_w5", 32'(st), 32'd0);
            if (i == 5) chk("t2_stall_w6", 32'(st), 32'(FL - 3));
        end
        drain();
        @(posedge clk);
        #1;

        // Push coinciding with a pop at count 2, then enough writes to wrap
        wr(8'h10, 1'b0, acc_a, st);
        wr(8'h20, 1'b1, acc, st);
        wr(8'h30, 1'b1, acc, st);
        until_cyc(acc_a + FL);
        wr(8'h40, 1'b1, acc, st);
        chk("t3_push_pop_stall", 32'(st), 32'd0);
        chk("t3_push_pop_cycle", 32'(acc - acc_a), 32'(FL + 1));
        @(negedge clk);
        chk("t3_push_pop_count", 32'(fifo_count), 32'd2);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) wr(bytes3[i], 1'b1, acc, st);
        drain();
        @(posedge clk);
        #1;

        // Reset during bit 3 of 0xA3 with two entries queued
        wr(8'hA3, 1'b0, acc_a, st);
        wr(8'h11, 1'b1, acc, st);
        wr(8'h22, 1'b1, acc, st);
        until_cyc(acc_a + 17);
        @(negedge clk);
        chk("t4_pre_count", 32'(fifo_count), 32'd2);
        chk("t4_pre_tx_bit2", 32'(tx), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        sbq.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("t4_tx", 32'(tx), 32'd1);
        chk("t4_count", 32'(fifo_count), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(frame_done), 32'd0);
        chk("t4_ready", 32'(wr_ready), 32'd1);
        repeat (6) @(negedge clk);
        chk("t4_idle_count", 32'(fifo_count), 32'd0);
        @(posedge clk);
        #1;
        wr(8'h3C, 1'b0, acc, st);
        drain();
        @(posedge clk);
        #1;

        // DATA_BITS=7, STOP_BITS=2 instance (and parity instances when enabled)
        valid_x = 1'b1;
        data_b  = 8'hFF;
        @(negedge clk);
        chk("tb_ready", 32'(ready_b), 32'd1);
        @(posedge clk);
        #1;
        valid_x = 1'b0;
        ndb = 0;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            tb_s[k] = tx_b;
            db_s[k] = done_b;
            if (done_b === 1'b1) ndb++;
`ifdef UART_TX_PARITY_EN
            if (k == 37) begin
                chk("p0_bit7", 32'(tx_p0), 32'd0);
                chk("p1_bit7", 32'(tx_p1), 32'd0);
            end
            if (k == 38) begin
                chk("p0_parity_even", 32'(tx_p0), 32'd1);
                chk("p1_parity_odd", 32'(tx_p1), 32'd0);
            end
            if (k == 41) begin
                chk("p0_parity_end", 32'(tx_p0), 32'd1);
                chk("p1_parity_end", 32'(tx_p1), 32'd0);
            end
            if (k == 45) begin
                chk("p0_done_44cyc", 32'(done_p0), 32'd1);
                chk("p1_done_44cyc", 32'(done_p1), 32'd1);
            end
`endif
        end
        chk("tb_start_k2", 32'(tb_s[2]), 32'd0);
        chk("tb_start_k5", 32'(tb_s[5]), 32'd0);
        chk("tb_bit0", 32'(tb_s[6]), 32'd1);
        chk("tb_bit6", 32'(tb_s[33]), 32'd1);
        chk("tb_stop_first", 32'(tb_s[34]), 32'd1);
        chk("tb_stop_last", 32'(tb_s[41]), 32'd1);
        chk("tb_done_k41", 32'(db_s[41]), 32'd1);
        chk("tb_done_k37", 32'(db_s[37]), 32'd0);
        chk("tb_done_cnt", 32'(ndb), 32'd1);
        chk("tb_idle_after", 32'(tb_s[44]), 32'd1);

        // Totals: every completed frame pulsed frame_done once, the aborted one never
        chk("frames_completed", 32'(frames_ok), 32'd17);
        chk("frame_done_total", 32'(done_total), 32'd17);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame, legal range 5..8.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 860, meaning clk cycles per bit, minimum 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning byte queue entries, a power of two, minimum 2.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  the single clock; every register updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port wr_valid  input  1  write request.
REQ-008 SHALL have port wr_data  input  8  byte to send; bits above DATA_BITS-1 are ignored.
REQ-009 SHALL have port wr_ready  output  1  FIFO can accept a write.
REQ-010 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-011 SHALL have port busy  output  1  frame in progress or FIFO not empty.
REQ-012 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

Function
REQ-014 SHALL accept a write when wr_valid and wr_ready are both high at a clk edge.
REQ-015 SHALL drive wr_ready = (fifo_count != FIFO_DEPTH) from registered state, so a write SHALL NOT be accepted while the FIFO is full, even in a cycle that pops.
REQ-016 SHALL, on a simultaneous push and pop with the FIFO not full, leave fifo_count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 SHALL implement an FSM with states IDLE, START, DATA, PAR, STOP.
REQ-018 SHALL, in IDLE with FIFO non-empty, pop the head entry and enter START on the next edge; a write to an empty FIFO SHALL put the start bit on tx 2 cycles after the accepting edge.
REQ-019 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles, timed by a bit counter that is cleared on every state change.
REQ-020 SHALL drive tx low in START, payload LSB-first over DATA_BITS bits in DATA, the parity bit in PAR (when enabled), and high for STOP_BITS bit-times in STOP.
REQ-021 SHALL, at the end of STOP, go to START directly if the FIFO is non-empty (back-to-back frames with no idle gap), otherwise to IDLE.
REQ-022 SHALL pulse frame_done once per frame; busy SHALL fall in the same cycle as the last frame_done when the FIFO is empty.
REQ-023 SHALL keep tx high in IDLE.

Reset
REQ-024 SHALL, when rst is sampled high, set state to IDLE, tx=1, busy=0, frame_done=0, fifo_count=0, wr_ready=1, and clear the pointers and counters.
REQ-025 SHALL, on rst mid-frame, abort the frame and flush the FIFO; tx SHALL be high from the first edge with rst high.
REQ-026 SHALL ignore a write in any cycle where rst is high.

Configuration
REQ-027 SHALL honour macro UART_TX_PARITY_EN: when defined, parameter PARITY_ODD (default 0) SHALL be added, and PAR SHALL send the XOR of the payload bits (even parity) or its inverse (odd parity).
REQ-028 SHALL, without UART_TX_PARITY_EN, skip PAR entirely (DATA goes to STOP) and omit PARITY_ODD.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4, STOP_BITS=1, parity off unless stated)
REQ-029 SHALL check: write 0x55 -> tx low for cycles 2-5 after the accept, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles; frame_done pulses once; 40-cycle frame.
REQ-030 SHALL check: 5 writes with tx idle -> first 5 accepted (1 is popped immediately); write 6 stalls with wr_ready=0 until the next pop; frames run back-to-back with no idle cycles; bytes arrive in order.
REQ-031 SHALL check: push and pop in the same cycle at fifo_count=2 -> fifo_count stays 2; pointer wrap after 9 writes -> data is in order.
REQ-032 SHALL check: rst asserted during bit 3 of 0xA3 with 2 entries queued -> next edge gives tx=1, fifo_count=0, busy=0; no frame_done.
REQ-033 SHALL check: UART_TX_PARITY_EN defined with PARITY_ODD=0 and byte 0x07 -> parity bit 1 (44-cycle frame); with PARITY_ODD=1 -> parity bit 0.
REQ-034 SHALL check: STOP_BITS=2 and DATA_BITS=7 with byte 0xFF -> bit 7 is not sent; stop level is high for 8 cycles; frame is 40 cycles.
